vmx_tile_scheduler: RTL and testbench
=====================================

Name: vmx_tile_scheduler

Overview:
- Sequences the VMX matrix-multiply wrapper over a run of consecutive tiles held in the shared 8-bit-addressed buffer.
- Per tile: drives the wrapper's read/write base addresses, pulses its start bit, then waits for the wrapper's state flag to return to idle.
- Advances addresses by programmable strides, counts tiles, and reports done or error.
- Sits between the PS-facing register block and the wrapper's rbase_addr/wbase_addr/ctrl/flag ports.

Parameters:
- PE_SIZE, 4, systolic array dimension; sets default strides.
- TIMEOUT, 255, max cycles allowed in any single wait state before error; must be ≥ 4*PE_SIZE+8.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- job_start  in  1  one-cycle pulse; accepted only in S_IDLE, ignored otherwise
- job_abort  in  1  level; aborts the current job
- num_tiles  in  8  tiles to run; sampled at accept
- rbase_init  in  8  first tile read base; sampled at accept
- wbase_init  in  8  first tile write base; sampled at accept
- rstride  in  8  read-address increment per tile (nominal 2*PE_SIZE); sampled at accept
- wstride  in  8  write-address increment per tile (nominal PE_SIZE); sampled at accept
- vmx_flag  in  3  wrapper state: 0 idle, 1–4 busy
- rbase_addr  out  8  to wrapper
- wbase_addr  out  8  to wrapper
- vmx_ctrl  out  2  bit1 start, bit0 soft reset; wrapper ctrl[31:2] tied 0 at top level
- busy  out  1  high from accept until the job ends
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky timeout flag; cleared on the next accepted job_start
- tiles_done  out  8  completed tile count for the current or last job

Behaviour:
- Reset (synchronous, rst_n=0 at posedge): state S_IDLE; all outputs 0; internal timer 0. rst_n dominates every other input.
- All outputs are registered.
- States: S_IDLE, S_ARM, S_WAIT, S_NEXT, S_ABORT.
- S_IDLE, job_start=1, num_tiles≠0:
  - Latch num_tiles and both strides.
  - rbase_addr←rbase_init, wbase_addr←wbase_init.
  - tiles_done←0, err←0, busy←1, go to S_ARM.
- S_IDLE, job_start=1, num_tiles=0:
  - err←0, tiles_done←0.
  - done pulses the next cycle; busy never asserts.
- S_ARM:
  - vmx_ctrl[1]=1 every cycle in this state.
  - On vmx_flag≠0: go to S_WAIT; vmx_ctrl[1] drops the same edge.
- S_WAIT:
  - vmx_ctrl=0.
  - On vmx_flag==0: go to S_NEXT.
- S_NEXT (one cycle):
  - tiles_done+1.
  - rbase_addr+=rstride, wbase_addr+=wstride, both modulo 256 (wrap silently).
  - If new tiles_done==num_tiles: done=1, busy←0, go to S_IDLE. Else go to S_ARM.
- Timeout:
  - Timer clears on entry to S_ARM and S_WAIT and increments every cycle in either state.
  - Timer reaching TIMEOUT: err←1, go to S_ABORT.
- Abort: job_abort=1 in S_ARM, S_WAIT or S_NEXT goes to S_ABORT. Abort takes priority over any same-cycle transition, including done.
- S_ABORT:
  - vmx_ctrl[0]=1 for exactly 2 cycles, holding the wrapper in reset; vmx_ctrl[1]=0.
  - Then busy←0, go to S_IDLE; no done pulse.
  - tiles_done keeps the count of fully completed tiles.
- job_abort in S_IDLE: no effect.
- job_start while busy: ignored, with no side effects.
- Config inputs are don't-care except in the accept cycle.
- Latency: accept → vmx_ctrl[1] high is 1 cycle; flag idle → next vmx_ctrl[1] is 2 cycles (S_NEXT, then S_ARM).

Test Plan:
- Single tile: num_tiles=1, rbase_init=0x10, wbase_init=0x80; behavioural wrapper model busy 12 cycles → vmx_ctrl[1] high until flag≠0; done 1 cycle after flag returns to 0; tiles_done=1; busy low.
- Multi-tile with wrap: num_tiles=3, rbase_init=0xF0, rstride=8, wbase_init=0xFC, wstride=4 → rbase_addr sequence F0,F8,00; wbase_addr sequence FC,00,04; exactly 3 start windows; one done pulse.
- Zero tiles: num_tiles=0 → done next cycle; busy and vmx_ctrl stay 0.
- Timeout: model never leaves flag=2 → err=1 after TIMEOUT cycles in S_WAIT; vmx_ctrl[0] high exactly 2 cycles; no done; next job_start clears err.
- Abort mid-job: num_tiles=4, job_abort asserted during tile 2's S_WAIT → S_ABORT; tiles_done=1; vmx_ctrl=01 for 2 cycles; busy low; no done.
- Reset mid-job and ignored start: rst_n=0 for 1 cycle during S_ARM → all outputs 0 next cycle. job_start pulsed while busy → tile count and addresses unaffected.

Source files
------------

// File: rtl/vmx_tile_scheduler.sv
// vmx_tile_scheduler: runs the VMX matmul wrapper over a run of tiles.
// Steps base addresses by stride per tile, times out stalled waits, aborts.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   job_start       one-cycle pulse, accepted only when idle
//   job_abort       level, abandons the running job
//   num_tiles       tile count (sampled at accept)
//   rbase_init      first read base (sampled at accept)
//   wbase_init      first write base (sampled at accept)
//   rstride         read base step per tile (sampled at accept)
//   wstride         write base step per tile (sampled at accept)
//   vmx_flag        wrapper state, 0 = idle
//   rbase_addr      read base to wrapper
//   wbase_addr      write base to wrapper
//   vmx_ctrl        [1] start, [0] soft reset
//   busy            job in progress
//   done            one-cycle pulse on successful completion
//   err             sticky timeout flag, cleared by next accept
//   tiles_done      completed tile count
module vmx_tile_scheduler #(
    parameter int PE_SIZE = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       job_start,
    input  logic       job_abort,
    input  logic [7:0] num_tiles,
    input  logic [7:0] rbase_init,
    input  logic [7:0] wbase_init,
    input  logic [7:0] rstride,
    input  logic [7:0] wstride,
    input  logic [2:0] vmx_flag,
    output logic [7:0] rbase_addr,
    output logic [7:0] wbase_addr,
    output logic [1:0] vmx_ctrl,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] tiles_done
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // A single tile needs at least this long to arm and drain.
    if (TIMEOUT < 4 * PE_SIZE + 8) begin : g_bad_timeout
        $error("TIMEOUT too small for PE_SIZE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_NEXT,
        S_ABORT
    } state_t;

    state_t        state;
    logic [7:0]    num_q;
    logic [7:0]    rstride_q;
    logic [7:0]    wstride_q;
    logic [TW-1:0] timer;
    logic          timeout;
    logic [7:0]    tiles_nxt;

    // Fires on the last allowed cycle, so a wait lasts TIMEOUT cycles.
    assign timeout   = (timer == TW'(TIMEOUT - 1));
    assign tiles_nxt = tiles_done + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            num_q      <= '0;
            rstride_q  <= '0;
            wstride_q  <= '0;
            timer      <= '0;
            rbase_addr <= '0;
            wbase_addr <= '0;
            vmx_ctrl   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            tiles_done <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    vmx_ctrl <= 2'b00;
                    if (job_start) begin
                        err        <= 1'b0;
                        tiles_done <= '0;
                        if (num_tiles == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            num_q      <= num_tiles;
                            rstride_q  <= rstride;
                            wstride_q  <= wstride;
                            rbase_addr <= rbase_init;
                            wbase_addr <= wbase_init;
                            busy       <= 1'b1;
                            vmx_ctrl   <= 2'b10;
                            timer      <= '0;
                            state      <= S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (job_abort) begin
                        vmx_ctrl <= 2'b01;
                        timer    <= '0;
                        state    <= S_ABORT;
                    end else if (vmx_flag != 3'd0) begin
                        vmx_ctrl <= 2'b00;
                        timer    <= '0;
                        state    <= S_WAIT;
                    end else if (timeout) begin
                        err      <= 1'b1;
                        vmx_ctrl <= 2'b01;
                        timer    <= '0;
                        state    <= S_ABORT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT: begin
                    if (job_abort) begin
                        vmx_ctrl <= 2'b01;
                        timer    <= '0;
                        state    <= S_ABORT;
                    end else if (vmx_flag == 3'd0) begin
                        state <= S_NEXT;
                    end else if (timeout) begin
                        err      <= 1'b1;
                        vmx_ctrl <= 2'b01;
                        timer    <= '0;
                        state    <= S_ABORT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_NEXT: begin
                    // The wrapper has already drained, so the tile counts
                    // even if an abort lands here.
                    tiles_done <= tiles_nxt;
                    if (job_abort) begin
                        vmx_ctrl <= 2'b01;
                        timer    <= '0;
                        state    <= S_ABORT;
                    end else begin
                        rbase_addr <= rbase_addr + rstride_q;
                        wbase_addr <= wbase_addr + wstride_q;
                        if (tiles_nxt == num_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            vmx_ctrl <= 2'b10;
                            timer    <= '0;
                            state    <= S_ARM;
                        end
                    end
                end
                S_ABORT: begin
                    // Soft reset held for two cycles, counted on timer.
                    if (timer == TW'(1)) begin
                        vmx_ctrl <= 2'b00;
                        busy     <= 1'b0;
                        timer    <= '0;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vmx_tile_scheduler.sv
// tb_vmx_tile_scheduler: directed bench for vmx_tile_scheduler.
// Includes a small wrapper model that answers start pulses on vmx_flag.
module tb_vmx_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       job_start;
    logic       job_abort;
    logic [7:0] num_tiles;
    logic [7:0] rbase_init;
    logic [7:0] wbase_init;
    logic [7:0] rstride;
    logic [7:0] wstride;
    logic [2:0] vmx_flag;
    logic [7:0] rbase_addr;
    logic [7:0] wbase_addr;
    logic [1:0] vmx_ctrl;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] tiles_done;

    int checks = 0;
    int errors = 0;

    vmx_tile_scheduler #(
        .PE_SIZE(4),
        .TIMEOUT(255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .job_start (job_start),
        .job_abort (job_abort),
        .num_tiles (num_tiles),
        .rbase_init(rbase_init),
        .wbase_init(wbase_init),
        .rstride   (rstride),
        .wstride   (wstride),
        .vmx_flag  (vmx_flag),
        .rbase_addr(rbase_addr),
        .wbase_addr(wbase_addr),
        .vmx_ctrl  (vmx_ctrl),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tiles_done(tiles_done)
    );

    always #5 clk = ~clk;

    // Wrapper model: a start seen while idle keeps flag busy 12 cycles,
    // or forever when hang is set; soft reset returns it to idle.
    logic hang = 1'b0;
    int   mcnt = 0;
    always @(posedge clk) begin
        if (!rst_n || vmx_ctrl[0]) begin
            vmx_flag <= 3'd0;
            mcnt     <= 0;
        end else if (vmx_flag == 3'd0) begin
            if (vmx_ctrl[1]) begin
                vmx_flag <= hang ? 3'd2 : 3'd1;
                mcnt     <= 12;
            end
        end else if (!hang) begin
            if (mcnt == 1) vmx_flag <= 3'd0;
            else mcnt <= mcnt - 1;
        end
    end

    // Observer: logs addresses at each start window and counts done pulses.
    int         nstart = 0;
    int         ndone = 0;
    logic       prev1 = 1'b0;
    logic [7:0] rlog[64];
    logic [7:0] wlog[64];
    always @(negedge clk) begin
        prev1 <= vmx_ctrl[1];
        if (done === 1'b1) ndone <= ndone + 1;
        if (vmx_ctrl[1] === 1'b1 && !prev1) begin
            rlog[nstart % 64] <= rbase_addr;
            wlog[nstart % 64] <= wbase_addr;
            nstart <= nstart + 1;
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [7:0] n, input logic [7:0] rb,
                             input logic [7:0] wb, input logic [7:0] rs,
                             input logic [7:0] ws);
        num_tiles  = n;
        rbase_init = rb;
        wbase_init = wb;
        rstride    = rs;
        wstride    = ws;
        job_start  = 1'b1;
        tick();
        job_start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rbase"}, {24'd0, rbase_addr}, 32'h0);
        chk({tag, "_wbase"}, {24'd0, wbase_addr}, 32'h0);
        chk({tag, "_ctrl"}, {30'd0, vmx_ctrl}, 32'h0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'h0);
        chk({tag, "_done"}, {31'd0, done}, 32'h0);
        chk({tag, "_err"}, {31'd0, err}, 32'h0);
        chk({tag, "_tiles"}, {24'd0, tiles_done}, 32'h0);
    endtask

    initial begin
        int s0;
        int d0;
        int cyc;
        rst_n      = 1'b0;
        job_start  = 1'b0;
        job_abort  = 1'b0;
        num_tiles  = '0;
        rbase_init = '0;
        wbase_init = '0;
        rstride    = '0;
        wstride    = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single tile, wrapper busy for 12 cycles.
        d0 = ndone;
        start_job(8'd1, 8'h10, 8'h80, 8'd8, 8'd4);
        chk("t1_ctrl_arm", {30'd0, vmx_ctrl}, 32'h2);
        chk("t1_busy", {31'd0, busy}, 32'h1);
        chk("t1_rbase", {24'd0, rbase_addr}, 32'h10);
        chk("t1_wbase", {24'd0, wbase_addr}, 32'h80);
        tick();
        chk("t1_ctrl_arm2", {30'd0, vmx_ctrl}, 32'h2);
        tick();
        chk("t1_ctrl_wait", {30'd0, vmx_ctrl}, 32'h0);
        repeat (12) tick();
        chk("t1_done_early", {31'd0, done}, 32'h0);
        chk("t1_busy_next", {31'd0, busy}, 32'h1);
        tick();
        chk("t1_done", {31'd0, done}, 32'h1);
        chk("t1_tiles", {24'd0, tiles_done}, 32'h1);
        chk("t1_busy_end", {31'd0, busy}, 32'h0);
        tick();
        chk("t1_done_pulse", {31'd0, done}, 32'h0);
        chk("t1_ndone", ndone - d0, 32'd1);

        // Three tiles with address wrap.
        s0 = nstart;
        d0 = ndone;
        start_job(8'd3, 8'hF0, 8'hFC, 8'd8, 8'd4);
        wait_done("t2_timeout", 300);
        tick();
        tick();
        chk("t2_starts", nstart - s0, 32'd3);
        chk("t2_r0", {24'd0, rlog[s0 % 64]}, 32'hF0);
        chk("t2_r1", {24'd0, rlog[(s0 + 1) % 64]}, 32'hF8);
        chk("t2_r2", {24'd0, rlog[(s0 + 2) % 64]}, 32'h00);
        chk("t2_w0", {24'd0, wlog[s0 % 64]}, 32'hFC);
        chk("t2_w1", {24'd0, wlog[(s0 + 1) % 64]}, 32'h00);
        chk("t2_w2", {24'd0, wlog[(s0 + 2) % 64]}, 32'h04);
        chk("t2_ndone", ndone - d0, 32'd1);
        chk("t2_tiles", {24'd0, tiles_done}, 32'h3);
        chk("t2_rbase_end", {24'd0, rbase_addr}, 32'h08);
        chk("t2_wbase_end", {24'd0, wbase_addr}, 32'h08);

        // Zero tiles.
        start_job(8'd0, 8'h55, 8'h66, 8'd8, 8'd4);
        chk("t3_done", {31'd0, done}, 32'h1);
        chk("t3_busy", {31'd0, busy}, 32'h0);
        chk("t3_ctrl", {30'd0, vmx_ctrl}, 32'h0);
        chk("t3_tiles", {24'd0, tiles_done}, 32'h0);
        tick();
        chk("t3_done_pulse", {31'd0, done}, 32'h0);
        chk("t3_busy2", {31'd0, busy}, 32'h0);

        // Wrapper hangs: timeout after 255 cycles in the wait state.
        hang = 1'b1;
        d0 = ndone;
        start_job(8'd1, 8'h00, 8'h00, 8'd8, 8'd4);
        cyc = 1;
        while (err !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("t4_err_cycle", cyc, 32'd258);
        chk("t4_err", {31'd0, err}, 32'h1);
        chk("t4_ctrl_rst1", {30'd0, vmx_ctrl}, 32'h1);
        tick();
        chk("t4_ctrl_rst2", {30'd0, vmx_ctrl}, 32'h1);
        tick();
        chk("t4_ctrl_end", {30'd0, vmx_ctrl}, 32'h0);
        chk("t4_busy_end", {31'd0, busy}, 32'h0);
        chk("t4_err_sticky", {31'd0, err}, 32'h1);
        hang = 1'b0;
        tick();
        chk("t4_no_done", ndone - d0, 32'd0);
        start_job(8'd1, 8'h00, 8'h00, 8'd8, 8'd4);
        chk("t4_err_clear", {31'd0, err}, 32'h0);
        wait_done("t4_recover_timeout", 100);
        chk("t4_recover_tiles", {24'd0, tiles_done}, 32'h1);
        tick();

        // Abort during the second tile's wait.
        s0 = nstart;
        d0 = ndone;
        start_job(8'd4, 8'h00, 8'h00, 8'd8, 8'd4);
        cyc = 0;
        while (!((nstart - s0) == 2 && vmx_ctrl == 2'b00) && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("t5_reach_tile2", nstart - s0, 32'd2);
        job_abort = 1'b1;
        tick();
        job_abort = 1'b0;
        chk("t5_ctrl_rst1", {30'd0, vmx_ctrl}, 32'h1);
        chk("t5_tiles", {24'd0, tiles_done}, 32'h1);
        chk("t5_rbase", {24'd0, rbase_addr}, 32'h08);
        tick();
        chk("t5_ctrl_rst2", {30'd0, vmx_ctrl}, 32'h1);
        chk("t5_busy_hold", {31'd0, busy}, 32'h1);
        tick();
        chk("t5_ctrl_end", {30'd0, vmx_ctrl}, 32'h0);
        chk("t5_busy_end", {31'd0, busy}, 32'h0);
        chk("t5_err", {31'd0, err}, 32'h0);
        tick();
        chk("t5_no_done", ndone - d0, 32'd0);
        chk("t5_tiles_kept", {24'd0, tiles_done}, 32'h1);

        // Reset while arming.
        start_job(8'd2, 8'h33, 8'h44, 8'd8, 8'd4);
        chk("t6_armed", {30'd0, vmx_ctrl}, 32'h2);
        rst_n = 1'b0;
        tick();
        chk_all_zero("t6_rst");
        rst_n = 1'b1;
        tick();

        // Start pulsed while busy is ignored.
        s0 = nstart;
        d0 = ndone;
        start_job(8'd3, 8'h20, 8'h40, 8'd8, 8'd4);
        cyc = 0;
        while (!((nstart - s0) == 1 && vmx_ctrl == 2'b00) && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("t6_reach_wait", nstart - s0, 32'd1);
        start_job(8'd1, 8'hAA, 8'hBB, 8'd1, 8'd1);
        chk("t6_ign_rbase", {24'd0, rbase_addr}, 32'h20);
        chk("t6_ign_tiles", {24'd0, tiles_done}, 32'h0);
        chk("t6_ign_busy", {31'd0, busy}, 32'h1);
        wait_done("t6_timeout", 300);
        chk("t6_tiles", {24'd0, tiles_done}, 32'h3);
        tick();
        tick();
        chk("t6_starts", nstart - s0, 32'd3);
        chk("t6_r1", {24'd0, rlog[(s0 + 1) % 64]}, 32'h28);
        chk("t6_r2", {24'd0, rlog[(s0 + 2) % 64]}, 32'h30);
        chk("t6_w2", {24'd0, wlog[(s0 + 2) % 64]}, 32'h48);
        chk("t6_ndone", ndone - d0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
